// File: rtl/alu_result_display.sv
// alu_result_display: captures ALU Result/ALUFlags on load, converts Result to
// two BCD digits with a sequential shift-add-3 engine, and drives a 4-digit
// multiplexed active-low 7-segment display plus flag LEDs.
// Optional feature macro: FLAG_STICKY_EN (flag LEDs accumulate across operations).
module alu_result_display #(
    parameter int REFRESH_BITS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [4:0] result,
    input  logic [3:0] alu_flags,
    input  logic       clr_flags,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [3:0] flag_led
);

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'b0111111;

    state_t                  state, state_nx;
    logic [4:0]              shreg;
    logic [7:0]              bcd;
    logic [7:0]              bcd_adj;
    logic [12:0]             sh_next;
    logic [2:0]              bit_cnt;
    logic [3:0]              flag_hold;
    logic [3:0]              ones, tens;
    logic                    disp_n;
    logic [REFRESH_BITS-1:0] cnt;
    logic [1:0]              sel;

    // Active-low segment code for one decimal digit.
    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'b1000000;
            4'd1:    digit_seg = 7'b1111001;
            4'd2:    digit_seg = 7'b0100100;
            4'd3:    digit_seg = 7'b0110000;
            4'd4:    digit_seg = 7'b0011001;
            4'd5:    digit_seg = 7'b0010010;
            4'd6:    digit_seg = 7'b0000010;
            4'd7:    digit_seg = 7'b1111000;
            4'd8:    digit_seg = 7'b0000000;
            4'd9:    digit_seg = 7'b0010000;
            default: digit_seg = BLANK;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic: IDLE -> CONV (5 shift steps) -> UPDATE -> IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = CONV;
            CONV:    if (bit_cnt == 3'd4) state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Add-3 correction on each BCD nibble, then shift the whole {bcd,shreg} left.
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
        sh_next = {bcd_adj, shreg} << 1;
    end

    // Conversion datapath and display digit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            flag_hold <= '0;
            ones      <= '0;
            tens      <= '0;
            disp_n    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == UPDATE);
            case (state)
                IDLE: if (load) begin
                    shreg     <= result;
                    flag_hold <= alu_flags;
                    bcd       <= '0;
                    bit_cnt   <= '0;
                end
                CONV: begin
                    bcd     <= sh_next[12:5];
                    shreg   <= sh_next[4:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                UPDATE: begin
                    ones   <= bcd[3:0];
                    tens   <= bcd[7:4];
                    disp_n <= flag_hold[3];
                end
                default: ;
            endcase
        end
    end

    // Flag LEDs: UPDATE wins over a coincident clear; clear applies otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_led <= '0;
        end else if (state == UPDATE) begin
`ifdef FLAG_STICKY_EN
            flag_led <= clr_flags ? flag_hold : (flag_led | flag_hold);
`else
            flag_led <= flag_hold;
`endif
        end else if (clr_flags) begin
            flag_led <= '0;
        end
    end

    // Free-running scan counter; top two bits select the active digit.
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt + 1'b1;
    end

    assign sel = cnt[REFRESH_BITS-1 -: 2];

    // Digit mux, driven only from registered state so inputs cannot glitch it.
    always_comb begin
        an  = 4'b1111;
        seg = BLANK;
        an[sel] = 1'b0;
        case (sel)
            2'd0:    seg = digit_seg(ones);
            2'd1:    seg = (tens == 4'd0) ? BLANK : digit_seg(tens);
            2'd2:    seg = BLANK;
            default: seg = disp_n ? DASH : BLANK;
        endcase
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display (REFRESH_BITS=4 for fast scanning).
// Reference model works on decimal values (v%10, v/10) and a cycle counter.
module tb_alu_result_display;

    logic       clk = 1'b0;
    logic       reset, load, clr_flags;
    logic [4:0] result;
    logic [3:0] alu_flags;
    logic       busy, done;
    logic [6:0] seg;
    logic [3:0] an, flag_led;

    int checks = 0;
    int failures = 0;

    // model state
    int       mcnt = 0;
    int       m_val = 0;
    bit       m_n = 1'b0;
    bit [3:0] m_flags = 4'd0;

    alu_result_display #(.REFRESH_BITS(4)) dut (
        .clk(clk), .reset(reset), .load(load), .result(result),
        .alu_flags(alu_flags), .clr_flags(clr_flags), .busy(busy),
        .done(done), .seg(seg), .an(an), .flag_led(flag_led)
    );

    always #5 clk = ~clk;

    // model of the scan position: cycles since reset released
    always @(posedge clk) begin
        if (reset) mcnt <= 0;
        else       mcnt <= mcnt + 1;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
            3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
            6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
            9: return 7'b0010000; default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 16 cycles = one full scan with REFRESH_BITS=4; check each cycle
    task automatic check_display();
        int sel;
        logic [6:0] es;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            sel = (mcnt % 16) / 4;
            case (sel)
                0: es = seg_of(m_val % 10);
                1: es = (m_val / 10 == 0) ? 7'h7F : seg_of(m_val / 10);
                2: es = 7'h7F;
                default: es = m_n ? 7'b0111111 : 7'h7F;
            endcase
            chk("an", an, 4'b1111 & ~(4'b0001 << sel));
            chk("seg", seg, es);
        end
    endtask

    function automatic bit [3:0] upd_flags(input bit [3:0] cur, input bit [3:0] f, input bit clr);
`ifdef FLAG_STICKY_EN
        return clr ? f : (cur | f);
`else
        return f;
`endif
    endfunction

    // Called at a negedge; leaves the bench at the negedge of the done cycle.
    // busy_ld: pulse a second load (value 25) while busy; it must be dropped.
    task automatic run_op(input logic [4:0] v, input logic [3:0] f, input bit clr, input bit busy_ld);
        result = v; alu_flags = f; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("busy_e0", busy, 1'b1);
        chk("done_e0", done, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            if (busy_ld && k == 2) begin result = 5'd25; load = 1'b1; end
            if (clr && k == 5) clr_flags = 1'b1;
            @(negedge clk);
            load = 1'b0;
            result = v;
            chk("busy_conv", busy, 1'b1);
            chk("done_conv", done, 1'b0);
        end
        @(negedge clk);  // after E6
        clr_flags = 1'b0;
        m_val = v; m_n = f[3]; m_flags = upd_flags(m_flags, f, clr);
        chk("busy_upd", busy, 1'b0);
        chk("done_upd", done, 1'b1);
        chk("flag_led", flag_led, m_flags);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("done_drop", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; clr_flags = 1'b0; result = '0; alu_flags = '0;
        repeat (2) @(negedge clk);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, 7'b1000000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_flag", flag_led, 4'b0000);
        reset = 1'b0;
        check_display();

        // directed values
        run_op(5'd31, 4'b1000, 1'b0, 1'b0); idle_cycle(); check_display();
        run_op(5'd7,  4'b0100, 1'b0, 1'b0); idle_cycle(); check_display();
        run_op(5'd0,  4'b0010, 1'b0, 1'b0); idle_cycle(); check_display();
        run_op(5'd9,  4'b0001, 1'b0, 1'b0); idle_cycle(); check_display();
        run_op(5'd10, 4'b1001, 1'b0, 1'b0); idle_cycle(); check_display();
        run_op(5'd19, 4'b0000, 1'b0, 1'b0); idle_cycle(); check_display();
        run_op(5'd20, 4'b1100, 1'b0, 1'b0); idle_cycle(); check_display();

        // load while busy dropped; load in done cycle accepted
        run_op(5'd12, 4'b0000, 1'b0, 1'b1);
        run_op(5'd25, 4'b0000, 1'b0, 1'b0); idle_cycle(); check_display();

        // flag accumulation / clear
        run_op(5'd3, 4'b0001, 1'b0, 1'b0); idle_cycle();
        run_op(5'd4, 4'b0010, 1'b0, 1'b0); idle_cycle();
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        m_flags = 4'd0;
        chk("clr_idle", flag_led, 4'b0000);
        run_op(5'd6, 4'b0100, 1'b0, 1'b0); idle_cycle();
        run_op(5'd8, 4'b1000, 1'b1, 1'b0); idle_cycle(); check_display();

        // randomized operations
        for (int i = 0; i < 20; i++) begin
            logic [4:0] rv;
            logic [3:0] rf;
            bit rc;
            rv = 5'($urandom_range(31));
            rf = 4'($urandom_range(15));
            rc = ($urandom_range(3) == 0);
            run_op(rv, rf, rc, 1'b0);
            idle_cycle();
            chk("rand_flag", flag_led, m_flags);
            check_display();
        end

        // reset mid-conversion aborts everything
        run_op(5'd18, 4'b1010, 1'b0, 1'b0); idle_cycle();
        result = 5'd5; alu_flags = 4'b1111; load = 1'b1;
        @(negedge clk);  // after E0
        load = 1'b0;
        @(negedge clk);  // after E1
        @(negedge clk);  // after E2: third CONV cycle
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_val = 0; m_n = 1'b0; m_flags = 4'd0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_flag", flag_led, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_nodone", done, 1'b0);
        end
        check_display();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
